// File: rtl/dmem_io_pkg.sv
// Shared constants and types for the CPU data-memory bus responder.
// Holds the register map, the ID word and the debouncer state encoding.
package dmem_io_pkg;

    localparam logic [31:0] ADDR_ID        = 32'h0000_0000;
    localparam logic [31:0] ADDR_LED       = 32'h0000_0001;
    localparam logic [31:0] ADDR_IN_STATUS = 32'h0000_0002;
    localparam logic [31:0] ADDR_IN_EDGE   = 32'h0000_0003;

    localparam logic [31:0] ID_VALUE = 32'h10C0_0001;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_sync.sv
// One-bit input conditioner: a two-flop synchroniser followed by a debouncer
// that accepts a change only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_sync
    import dmem_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DBC_W           = 20
) (
    input  logic CLK100MHZ,
    input  logic RST,
    input  logic din,
    output logic dout
);

    localparam logic [DBC_W-1:0] LAST_COUNT = DBC_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             dout_reg;
    logic [DBC_W-1:0] cnt_reg;
    db_state_t        state_reg;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            dout_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= DB_STABLE;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            case (state_reg)
                DB_STABLE: begin
                    cnt_reg <= '0;
                    if (sync2_reg != dout_reg) begin
                        // The first differing sample already counts toward the total.
                        if (LAST_COUNT == '0) begin
                            dout_reg <= ~dout_reg;
                        end else begin
                            cnt_reg   <= DBC_W'(1);
                            state_reg <= DB_COUNTING;
                        end
                    end
                end
                DB_COUNTING: begin
                    if (sync2_reg == dout_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= DB_STABLE;
                    end else if (cnt_reg == LAST_COUNT) begin
                        dout_reg  <= ~dout_reg;
                        cnt_reg   <= '0;
                        state_reg <= DB_STABLE;
                    end else begin
                        cnt_reg <= cnt_reg + DBC_W'(1);
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= DB_STABLE;
                end
            endcase
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/dmem_io_responder.sv
// Data-memory bus responder: scratch RAM, LED register, debounced button/switch
// status and sticky write-1-to-clear button rising-edge flags.
module dmem_io_responder
    import dmem_io_pkg::*;
#(
    parameter int          DMEM_WORDS      = 16,
    parameter logic [31:0] DMEM_BASE       = 32'h0000_0010,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          DBC_W           = 20
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [31:0] MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
    input  logic        MEM_ACCESS_READ_WRN,
    output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
    input  logic [3:0]  BTN,
    input  logic [3:0]  SW,
    output logic [3:0]  LED
);

    localparam int IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] ram_reg [DMEM_WORDS];
    logic [3:0]  led_reg;
    logic [3:0]  edge_reg;
    logic [3:0]  btn_db_d_reg;

    logic [7:0]  raw_in;
    logic [7:0]  db_in;
    logic [3:0]  btn_db;
    logic [3:0]  sw_db;
    logic [3:0]  btn_rise;
    logic [3:0]  edge_view;
    logic [3:0]  edge_clr;
    logic [31:0] ram_idx;
    logic        in_ram;
    logic        wr_en;
    logic [31:0] rdata;

    assign raw_in = {SW, BTN};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_in
            debounce_sync #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .DBC_W          (DBC_W)
            ) u_debounce (
                .CLK100MHZ(CLK100MHZ),
                .RST      (RST),
                .din      (raw_in[gi]),
                .dout     (db_in[gi])
            );
        end
    endgenerate

    assign btn_db = db_in[3:0];
    assign sw_db  = db_in[7:4];

    // Unsigned bounds on both sides, so addresses below the base never alias into RAM.
    assign ram_idx = MEM_ACCESS_ADDRESS_BUS - DMEM_BASE;
    assign in_ram  = (MEM_ACCESS_ADDRESS_BUS >= DMEM_BASE) && (ram_idx < 32'(DMEM_WORDS));
    assign wr_en   = ~MEM_ACCESS_READ_WRN;

    // A rise is visible to readers in the cycle the debounced level goes high.
    assign btn_rise  = btn_db & ~btn_db_d_reg;
    assign edge_view = edge_reg | btn_rise;
    assign edge_clr  = (wr_en && !in_ram && MEM_ACCESS_ADDRESS_BUS == ADDR_IN_EDGE)
                       ? MEM_ACCESS_DATA_OUT_BUS[3:0] : 4'h0;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                ram_reg[i] <= '0;
            end
        end else if (wr_en && in_ram) begin
            ram_reg[ram_idx[IDX_W-1:0]] <= MEM_ACCESS_DATA_OUT_BUS;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            led_reg      <= 4'h0;
            edge_reg     <= 4'h0;
            btn_db_d_reg <= 4'h0;
        end else begin
            btn_db_d_reg <= btn_db;
            if (wr_en && !in_ram && MEM_ACCESS_ADDRESS_BUS == ADDR_LED) begin
                led_reg <= MEM_ACCESS_DATA_OUT_BUS[3:0];
            end
            // Set wins over a simultaneous clear.
            edge_reg <= (edge_reg & ~edge_clr) | btn_rise;
        end
    end

    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = ram_reg[ram_idx[IDX_W-1:0]];
        end else begin
            case (MEM_ACCESS_ADDRESS_BUS)
                ADDR_ID:        rdata = ID_VALUE;
                ADDR_LED:       rdata = {28'h0, led_reg};
                ADDR_IN_STATUS: rdata = {24'h0, sw_db, btn_db};
                ADDR_IN_EDGE:   rdata = {28'h0, edge_view};
                default:        rdata = '0;
            endcase
        end
    end

    assign MEM_ACCESS_DATA_IN_BUS = rdata;
    assign LED                    = led_reg;

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed bench for dmem_io_responder with a short debounce window (4 cycles).
module tb_dmem_io_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rwn;
    logic [31:0] rdata;
    logic [3:0]  btn;
    logic [3:0]  sw;
    logic [3:0]  led;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_word;

    dmem_io_responder #(
        .DMEM_WORDS     (16),
        .DMEM_BASE      (32'h0000_0010),
        .DEBOUNCE_CYCLES(4),
        .DBC_W          (3)
    ) dut (
        .CLK100MHZ              (clk),
        .RST                    (rst),
        .MEM_ACCESS_ADDRESS_BUS (addr),
        .MEM_ACCESS_DATA_OUT_BUS(wdata),
        .MEM_ACCESS_READ_WRN    (rwn),
        .MEM_ACCESS_DATA_IN_BUS (rdata),
        .BTN                    (btn),
        .SW                     (sw),
        .LED                    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        rwn   = 1'b0;
        step();
        rwn   = 1'b1;
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; rwn = 1'b1; btn = 4'h0; sw = 4'h0;
        step();
        step();
        rst = 1'b0;

        rd(32'h0, "reset_id", 32'h10C0_0001);
        rd(32'h2, "reset_status", 32'h0);
        rd(32'h3, "reset_edge", 32'h0);
        rd(32'h10, "reset_ram0", 32'h0);
        chk("reset_led", {28'h0, led}, 32'h0);

        wr(32'h1, 32'hFFFF_FFF5);
        chk("led_drive", {28'h0, led}, 32'h5);
        rd(32'h1, "led_read", 32'h5);
        wr(32'h0, 32'h1234_5678);
        rd(32'h0, "id_readonly", 32'h10C0_0001);

        wr(32'h12, 32'hDEAD_BEEF);
        rd(32'h12, "ram_12", 32'hDEAD_BEEF);
        wr(32'h1F, 32'h0000_1F1F);
        rd(32'h1F, "ram_top", 32'h0000_1F1F);
        rd(32'h20, "unmapped_20", 32'h0);
        rd(32'hF, "unmapped_0f", 32'h0);
        rd(32'hFFFF_FFFF, "unmapped_wrap", 32'h0);
        wr(32'h20, 32'hA5A5_A5A5);
        rd(32'h20, "unmapped_20_after_wr", 32'h0);
        for (int i = 0; i < 16; i++) begin
            exp_word = (i == 2) ? 32'hDEAD_BEEF : (i == 15) ? 32'h0000_1F1F : 32'h0;
            rd(32'h10 + 32'(i), $sformatf("ram_scan_%0d", i), exp_word);
        end

        // BTN[2] press: debounced after exactly 6 edges.
        btn = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            step();
            rd(32'h2, $sformatf("btn2_wait_%0d", k), 32'h0);
        end
        step();
        rd(32'h2, "btn2_status", 32'h4);
        rd(32'h3, "btn2_edge", 32'h4);

        // Three-cycle glitch on BTN[0] must be rejected.
        btn = 4'b0101;
        step(); step(); step();
        btn = 4'b0100;
        for (int k = 0; k < 8; k++) step();
        rd(32'h2, "glitch_status", 32'h4);
        rd(32'h3, "glitch_edge", 32'h4);

        // BTN[1] accepted while clearing bit 2 in the same cycle.
        btn = 4'b0110;
        for (int k = 0; k < 5; k++) step();
        rd(32'h2, "btn1_before", 32'h4);
        step();
        rd(32'h2, "btn1_status", 32'h6);
        rd(32'h3, "btn1_edge_pre", 32'h6);
        wr(32'h3, 32'h4);
        rd(32'h3, "w1c_race", 32'h2);
        wr(32'h3, 32'hFFFF_FFF2);
        rd(32'h3, "w1c_clear", 32'h0);
        wr(32'h3, 32'h0);
        rd(32'h3, "falling_none", 32'h0);

        // Write and read the same RAM word in one cycle.
        addr = 32'h12; wdata = 32'h0000_1234; rwn = 1'b0;
        #1;
        chk("rw_same_old", rdata, 32'hDEAD_BEEF);
        step();
        chk("rw_same_new", rdata, 32'h0000_1234);
        step();
        chk("rw_hold", rdata, 32'h0000_1234);
        rwn = 1'b1;

        // SW[3] change interrupted by reset; buttons stay held through reset.
        sw = 4'b1000;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_led", {28'h0, led}, 32'h0);
        rd(32'h12, "rst_ram", 32'h0);
        rd(32'h1, "rst_led_reg", 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            rd(32'h2, $sformatf("sw3_wait_%0d", k), 32'h0);
        end
        step();
        rd(32'h2, "sw3_status", 32'h86);
        rd(32'h3, "held_btn_edge", 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
